// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and constants for the mips_cpu_bus memory arbiter slice.
//   arb_state_t : arbiter FSM states (idle, bus command in flight, read response)
//   owner_t     : which requester owns the current transaction (fetch or data)
//   BE_ALL      : full-word byte enable for a 32-bit bus
//   other_owner : returns the requester that is not the given one
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Used by the round-robin picker to hand the bus to whoever did not
  // get it last time.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mips_arb_select.sv
// mips_arb_select
// Combinational picker that decides which requester the arbiter latches
// when it is idle.
// Build option: MIPS_ARB_RR_EN
//   defined   : simultaneous requests go to the requester that is not last_grant
//   undefined : simultaneous requests go to the data port (D over I)
// Ports:
//   i_req      in   fetch request pending
//   d_req      in   data request pending
//   last_grant in   requester latched most recently
//   owner      out  requester to latch this cycle (only meaningful if a req is set)
module mips_arb_select
  import mips_bus_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output owner_t owner
);

  // A lone request always wins. On a collision the build option decides
  // between alternating and fixed data-first priority. With no request the
  // output simply parks on last_grant; the arbiter ignores it then.
  always_comb begin
    owner = last_grant;
    if (i_req && d_req) begin
`ifdef MIPS_ARB_RR_EN
      owner = other_owner(last_grant);
`else
      owner = OWNER_D;
`endif
    end else if (d_req) begin
      owner = OWNER_D;
    end else if (i_req) begin
      owner = OWNER_I;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares the single Avalon-MM master port of mips_cpu_bus between the
// instruction fetch unit (I) and the load/store unit (D). One transaction
// is latched at a time, held stable on the bus through waitrequest, and a
// read returns its data with a one-cycle valid pulse to the issuer.
// Build option: MIPS_ARB_RR_EN (round-robin on collisions instead of D over I)
// Parameters:
//   ADDR_W  bus address width
//   DATA_W  bus data width (byte enables are DATA_W/8 wide)
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   i_req/i_addr                   fetch request (always a full-word read)
//   i_gnt/i_rvalid/i_rdata         fetch accept pulse, read data pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be load/store request
//   d_gnt/d_rvalid/d_rdata         data accept pulse, read data pulse, data
//   address/read/write/writedata/byteenable/waitrequest/readdata
//                                  Avalon-MM master port
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state, state_next;
  owner_t     pick, last_grant, cmd_owner;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;

  logic any_req;
  logic latch;
  logic null_write;
  logic accepted;

  assign any_req = i_req | d_req;
  assign latch   = (state == ARB_IDLE) && any_req;

  // A store with no byte lanes enabled has nothing to put on the bus, so it
  // is acknowledged immediately and never raises write.
  assign null_write = cmd_we && (cmd_be == '0);

  // The command leaves ISSUE either when the slave drops waitrequest or
  // when there was never a bus cycle to begin with.
  assign accepted = (state == ARB_ISSUE) && (null_write || !waitrequest);

  mips_arb_select u_select (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .owner      (pick)
  );

`ifdef MIPS_ARB_RR_EN
  // Remember who was latched last so the next collision goes the other way.
  // Fetch counts as the previous owner out of reset, so the first collision
  // favours the data port.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWNER_I;
    end else if (latch) begin
      last_grant <= pick;
    end
  end
`else
  assign last_grant = OWNER_I;
`endif

  // State register. Reset abandons whatever transaction is in flight; since
  // the bus outputs decode from the state, read/write fall on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command registers. They are loaded only while idle and then stay frozen
  // so the bus sees a stable command for as long as waitrequest stalls it,
  // even if the requester misbehaves and changes or drops its inputs.
  // A fetch is always a full-word read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_owner <= OWNER_I;
      cmd_addr  <= '0;
      cmd_we    <= 1'b0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
    end else if (latch) begin
      cmd_owner <= pick;
      if (pick == OWNER_D) begin
        cmd_addr  <= d_addr;
        cmd_we    <= d_we;
        cmd_wdata <= d_wdata;
        cmd_be    <= d_be;
      end else begin
        cmd_addr  <= i_addr;
        cmd_we    <= 1'b0;
        cmd_wdata <= '0;
        cmd_be    <= {BE_W{1'b1}};
      end
    end
  end

  // Next-state and output decode. The bus is quiet outside ISSUE. Grants
  // pulse combinationally in the acceptance cycle, and read data is passed
  // straight through from the slave in the following RESP cycle. Neither
  // pulse is allowed while reset is asserted, so an abandoned transaction
  // never reports completion.
  always_comb begin
    state_next = state;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;

    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_next = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        if (!null_write) begin
          address    = cmd_addr;
          read       = !cmd_we;
          write      = cmd_we;
          writedata  = cmd_wdata;
          byteenable = cmd_be;
        end
        if (accepted) begin
          state_next = cmd_we ? ARB_IDLE : ARB_RESP;
          if (!reset) begin
            if (cmd_owner == OWNER_D) begin
              d_gnt = 1'b1;
            end else begin
              i_gnt = 1'b1;
            end
          end
        end
      end

      ARB_RESP: begin
        state_next = ARB_IDLE;
        if (!reset) begin
          if (cmd_owner == OWNER_D) begin
            d_rvalid = 1'b1;
            d_rdata  = readdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = readdata;
          end
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
// Self-checking bench for mips_mem_arbiter. Two requester models and a bus
// slave are driven from queues and $urandom; a transaction-level reference
// predicts every output each cycle. Directed sequences cover the fetch,
// stalled store, collision, empty store, reset and back-to-back cases.
// Honours MIPS_ARB_RR_EN the same way the design does.
module tb_mips_mem_arbiter;
  import mips_bus_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dreq_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester queues: the head of each queue is what that requester asserts.
  logic [31:0] i_q[$];
  dreq_t       d_q[$];

  bit          rnd_mode;
  bit          wait_force;
  logic [31:0] rd_force;
  bit          rst_in;
  int          cyc;
  int          checks;
  int          failures;

  // Reference model: the transaction currently on the bus (if any), the
  // pending read response (if any), and who was served last.
  bit    m_act;
  bit    m_act_d;
  dreq_t m_cmd;
  bit    m_resp;
  bit    m_resp_d;
  bit    m_last_d;

  // Observations of the DUT, cleared at the start of each directed case.
  int          n_i_gnt, n_d_gnt, n_i_rv, n_d_rv, n_wr_cyc;
  int          rd_cyc_q[$];
  int          i_gnt_cyc_q[$];
  int          d_gnt_cyc_q[$];
  int          i_rv_cyc_q[$];
  int          d_rv_cyc_q[$];
  bit          gnt_order_q[$];
  logic [31:0] i_rdata_seen;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic resetLogs();
    n_i_gnt = 0; n_d_gnt = 0; n_i_rv = 0; n_d_rv = 0; n_wr_cyc = 0;
    rd_cyc_q.delete(); i_gnt_cyc_q.delete(); d_gnt_cyc_q.delete();
    i_rv_cyc_q.delete(); d_rv_cyc_q.delete(); gnt_order_q.delete();
    i_rdata_seen = '0;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs after the rising edge, predict and compare
  // outputs at the falling edge, then advance the reference model.
  task automatic applyStimulus();
    dreq_t       r;
    bit          take, gi, gd, rvi, rvd, nullw, freeb, pd;
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    bit          er, ew;

    @(posedge clk);
    #1;
    if (rnd_mode) begin
      if (i_q.size() == 0 && $urandom_range(0, 9) < 5)
        i_q.push_back($urandom & 32'h0000_03FC);
      if (d_q.size() == 0 && $urandom_range(0, 9) < 5) begin
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.be    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        d_q.push_back(r);
      end
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata    = $urandom;
      rst_in      = ($urandom_range(0, 99) == 0);
    end else begin
      waitrequest = wait_force;
      readdata    = rd_force;
    end
    reset = rst_in;
    i_req = (i_q.size() != 0);
    if (i_req) i_addr = i_q[0];
    d_req = (d_q.size() != 0);
    if (d_req) begin
      d_we    = d_q[0].we;
      d_addr  = d_q[0].addr;
      d_wdata = d_q[0].wdata;
      d_be    = d_q[0].be;
    end

    @(negedge clk);
    ea = '0; ewd = '0; ebe = '0; er = 1'b0; ew = 1'b0;
    take = 1'b0; gi = 1'b0; gd = 1'b0; rvi = 1'b0; rvd = 1'b0;
    if (m_act) begin
      nullw = m_cmd.we && (m_cmd.be == 4'h0);
      if (!nullw) begin
        ea = m_cmd.addr; er = !m_cmd.we; ew = m_cmd.we; ewd = m_cmd.wdata; ebe = m_cmd.be;
      end
      take = nullw || !waitrequest;
      if (take && !reset) begin
        gi = !m_act_d;
        gd = m_act_d;
      end
    end
    if (m_resp && !reset) begin
      rvi = !m_resp_d;
      rvd = m_resp_d;
    end
    checkOutput("bus_cmd", 128'({address, read, write, writedata, byteenable}),
                128'({ea, er, ew, ewd, ebe}));
    checkOutput("requester_side", 128'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata}),
                128'({gi, gd, rvi, rvd, (rvi ? readdata : 32'h0), (rvd ? readdata : 32'h0)}));

    if (i_gnt)    begin n_i_gnt++; i_gnt_cyc_q.push_back(cyc); gnt_order_q.push_back(1'b0); end
    if (d_gnt)    begin n_d_gnt++; d_gnt_cyc_q.push_back(cyc); gnt_order_q.push_back(1'b1); end
    if (i_rvalid) begin n_i_rv++; i_rv_cyc_q.push_back(cyc); i_rdata_seen = i_rdata; end
    if (d_rvalid) begin n_d_rv++; d_rv_cyc_q.push_back(cyc); end
    if (write)    n_wr_cyc++;
    if (read)     rd_cyc_q.push_back(cyc);

    if (reset) begin
      m_act = 1'b0; m_resp = 1'b0; m_last_d = 1'b0;
      i_q.delete(); d_q.delete();
    end else begin
      freeb  = !m_act && !m_resp;
      m_resp = 1'b0;
      if (m_act && take) begin
        m_act = 1'b0;
        if (!m_cmd.we) begin
          m_resp   = 1'b1;
          m_resp_d = m_act_d;
        end
      end else if (freeb && (i_req || d_req)) begin
`ifdef MIPS_ARB_RR_EN
        pd = (i_req && d_req) ? !m_last_d : d_req;
`else
        pd = d_req;
`endif
        m_act    = 1'b1;
        m_act_d  = pd;
        m_last_d = pd;
        if (pd) m_cmd = d_q[0];
        else    m_cmd = '{we: 1'b0, addr: i_q[0], wdata: 32'h0, be: 4'hF};
      end
      if (gi) void'(i_q.pop_front());
      if (gd) void'(d_q.pop_front());
    end
    cyc++;
  endtask

  initial begin
    checks = 0; failures = 0;
    rnd_mode = 1'b0; wait_force = 1'b0; rd_force = '0; rst_in = 1'b1;
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; waitrequest = 1'b0; readdata = '0;
    m_act = 1'b0; m_act_d = 1'b0; m_cmd = '0; m_resp = 1'b0; m_resp_d = 1'b0; m_last_d = 1'b0;
    resetLogs();

    $display("[TB] reset");
    repeat (2) applyStimulus();
    rst_in = 1'b0;
    applyStimulus();
    checkOutput("reset_bus", 128'({address, read, write, writedata, byteenable}), 128'(0));
    checkOutput("reset_req_side", 128'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata}), 128'(0));

    $display("[TB] fetch, zero wait");
    resetLogs(); rd_force = 32'h2402_0005; wait_force = 1'b0;
    i_q.push_back(32'hBFC0_0000);
    repeat (5) applyStimulus();
    checkOutput("fetch_gnt_count", 128'(n_i_gnt), 128'(1));
    checkOutput("fetch_rvalid_count", 128'(n_i_rv), 128'(1));
    if (i_gnt_cyc_q.size() > 0) checkOutput("fetch_gnt_cycle", 128'(i_gnt_cyc_q[0]), 128'(1));
    if (i_rv_cyc_q.size() > 0)  checkOutput("fetch_rvalid_cycle", 128'(i_rv_cyc_q[0]), 128'(2));
    if (rd_cyc_q.size() > 0)    checkOutput("fetch_read_cycle", 128'(rd_cyc_q[0]), 128'(1));
    checkOutput("fetch_rdata", 128'(i_rdata_seen), 128'(32'h2402_0005));

    $display("[TB] store under waitrequest");
    resetLogs(); wait_force = 1'b1;
    d_q.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF, be: 4'hF});
    repeat (4) applyStimulus();
    wait_force = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("store_write_cycles", 128'(n_wr_cyc), 128'(4));
    checkOutput("store_gnt_count", 128'(n_d_gnt), 128'(1));
    checkOutput("store_no_rvalid", 128'(n_d_rv), 128'(0));
    if (d_gnt_cyc_q.size() > 0) checkOutput("store_gnt_cycle", 128'(d_gnt_cyc_q[0]), 128'(4));

    $display("[TB] collision");
    resetLogs();
    d_q.push_back('{we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, be: 4'hF});
    repeat (4) applyStimulus();
    resetLogs();
    d_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, be: 4'hF});
    i_q.push_back(32'h0000_0100);
    repeat (10) applyStimulus();
    checkOutput("collision_gnt_total", 128'(gnt_order_q.size()), 128'(2));
`ifdef MIPS_ARB_RR_EN
    if (gnt_order_q.size() > 0) checkOutput("collision_first_owner", 128'(gnt_order_q[0]), 128'(0));
`else
    if (gnt_order_q.size() > 0) checkOutput("collision_first_owner", 128'(gnt_order_q[0]), 128'(1));
`endif

    $display("[TB] zero byte enable store");
    resetLogs(); wait_force = 1'b1;
    d_q.push_back('{we: 1'b1, addr: 32'h0000_0080, wdata: 32'h1234_5678, be: 4'h0});
    repeat (4) applyStimulus();
    checkOutput("nullw_no_write", 128'(n_wr_cyc), 128'(0));
    checkOutput("nullw_gnt_count", 128'(n_d_gnt), 128'(1));
    if (d_gnt_cyc_q.size() > 0) checkOutput("nullw_gnt_cycle", 128'(d_gnt_cyc_q[0]), 128'(1));

    $display("[TB] reset during issue");
    resetLogs(); wait_force = 1'b1;
    d_q.push_back('{we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0, be: 4'hF});
    repeat (2) applyStimulus();
    rst_in = 1'b1;
    applyStimulus();
    rst_in = 1'b0;
    applyStimulus();
    checkOutput("rst_after_bus", 128'({address, read, write, writedata, byteenable}), 128'(0));
    applyStimulus();
    checkOutput("rst_read_cycles", 128'(rd_cyc_q.size()), 128'(2));
    checkOutput("rst_no_gnt_rvalid", 128'({n_d_gnt, n_d_rv}), 128'(0));
    wait_force = 1'b0;

    $display("[TB] back-to-back loads");
    resetLogs();
    d_q.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, be: 4'hF});
    d_q.push_back('{we: 1'b0, addr: 32'h0000_0014, wdata: 32'h0, be: 4'hF});
    repeat (7) applyStimulus();
    checkOutput("b2b_read_count", 128'(rd_cyc_q.size()), 128'(2));
    checkOutput("b2b_rvalid_count", 128'(d_rv_cyc_q.size()), 128'(2));
    if (rd_cyc_q.size() == 2)   checkOutput("b2b_cmd_cycles", 128'({rd_cyc_q[0], rd_cyc_q[1]}), 128'({32'd1, 32'd4}));
    if (d_rv_cyc_q.size() == 2) checkOutput("b2b_rvalid_cycles", 128'({d_rv_cyc_q[0], d_rv_cyc_q[1]}), 128'({32'd2, 32'd5}));

    $display("[TB] random traffic");
    rnd_mode = 1'b1;
    repeat (3000) applyStimulus();
    rnd_mode = 1'b0;
    rst_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
